apb_timer: RTL and testbench
============================

APB_TIMER -- requirements
Module: apb_timer

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 32, APB address width; DATA_WIDTH, 32, APB data width.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rts input 1, synchronous active-high reset.
REQ-003 paddr  input  ADDR_WIDTH: byte address; only paddr[4:0] decoded, base decode done by APB.
REQ-004 pdata  input  DATA_WIDTH: write data.
REQ-005 prdata  output  DATA_WIDTH: read data.
REQ-006 psel  input  1: slave select from APB.
REQ-007 penable  input  1: access phase.
REQ-008 pwrite  input  1: 1 = write, 0 = read.
REQ-009 pstb  input  4: byte write strobes; pstb[n] covers bits [8n+7:8n].
REQ-010 pready  output  1: transfer complete.
REQ-011 perr  output  1: slave error, valid only while pready=1.
REQ-012 irq  output  1: timer interrupt, level, registered.

Function
REQ-013 Register map: 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI, 0x10 CTRL (bit0 EN, bits[15:8] PRESCALE, all other bits read 0).
REQ-014 Handshake FSM states SHALL be IDLE, SETUP, WAIT, RESP: IDLE->SETUP on psel&!penable; SETUP->WAIT on psel&penable; WAIT->RESP unconditionally; RESP->IDLE unconditionally; any state->IDLE when psel=0.
REQ-015 pready SHALL be 1 only in RESP, giving exactly one wait state: pready rises 2 cycles after penable rises.
REQ-016 prdata SHALL be loaded in WAIT and held through RESP; prdata SHALL be 0 outside RESP and on errors.
REQ-017 perr SHALL be 1 in RESP when paddr[4:0] > 0x10 or paddr[1:0] != 0; an errored write SHALL modify no register.
REQ-018 Writes SHALL commit at the clk edge ending RESP, honouring pstb per byte; pstb=0 writes nothing and completes without error.
REQ-019 mtime (64-bit) SHALL increment by 1 per tick while EN=1, wrapping from 2^64-1 to 0 with no flag.
REQ-020 A write to MTIME_LO/HI SHALL take precedence over an increment in the same cycle; the written value is loaded unincremented.
REQ-021 Reading MTIME_HI SHALL return the upper half latched at the preceding MTIME_LO read (snapshot), ensuring coherent 64-bit reads.
REQ-022 irq SHALL be registered: irq <= EN & (mtime >= mtimecmp), unsigned 64-bit compare, 1 cycle latency.
REQ-023 Writing MTIMECMP above mtime SHALL clear irq on the following cycle; clearing EN SHALL clear irq on the following cycle and freeze mtime.

Reset
REQ-024 On clk edge with rts=1: FSM IDLE, prdata 0, pready 0, perr 0, irq 0, mtime 0, snapshot 0, mtimecmp 0xFFFF_FFFF_FFFF_FFFF, CTRL 0, prescale counter 0.
REQ-025 rts asserted mid-transfer SHALL abort it with no register write and no pready pulse.

Configuration
REQ-026 Macro TIMER_PRESCALE_EN defined: tick occurs when prescale counter equals PRESCALE, then counter returns to 0 (mtime advances every PRESCALE+1 cycles); writing CTRL resets the counter.
REQ-027 Macro TIMER_PRESCALE_EN undefined: tick every cycle, no counter logic, CTRL[15:8] read 0 and ignore writes.

Structure
REQ-028 Register offsets, CTRL bit positions, FSM state encoding and mtimecmp reset value SHALL reside in shared package soc_pkg.
REQ-029 APB handshake FSM SHALL be sub-module apb_resp_fsm (outputs state, pready, commit strobe), reusable by sram/uart.

Verification
REQ-030 Reset, then read 0x10 -> pready 2 cycles after penable, prdata 0x0, perr 0, irq 0.
REQ-031 Write CTRL=0x1, MTIMECMP_HI=0, MTIMECMP_LO=20 -> irq rises exactly 1 cycle after mtime reaches 20.
REQ-032 Write MTIME=0xFFFF_FFFF_FFFF_FFFE, EN=1 -> mtime reads 0 after 2 ticks; irq tracks compare across the wrap.
REQ-033 Write 0xAABBCCDD to 0x08 with pstb=0b0010 -> MTIMECMP_LO=0xFFFF_CCFF.
REQ-034 Read 0x14 and 0x06 -> perr=1, prdata=0; write 0x14 -> no register changes.
REQ-035 With TIMER_PRESCALE_EN, CTRL=0x0301 -> mtime increments every 4 cycles; without macro, CTRL reads 0x0001.

Source files
------------

// File: rtl/soc_pkg.sv
// Shared SoC definitions: APB timer register map, CTRL fields, APB handshake
// state encoding and reset constants, plus a byte-strobe merge helper.
package soc_pkg;

    localparam logic [4:0] MTIME_LO_OFF    = 5'h00;
    localparam logic [4:0] MTIME_HI_OFF    = 5'h04;
    localparam logic [4:0] MTIMECMP_LO_OFF = 5'h08;
    localparam logic [4:0] MTIMECMP_HI_OFF = 5'h0C;
    localparam logic [4:0] CTRL_OFF        = 5'h10;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_PRESC_LSB = 8;
    localparam int CTRL_PRESC_MSB = 15;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        APB_IDLE  = 2'd0,
        APB_SETUP = 2'd1,
        APB_WAIT  = 2'd2,
        APB_RESP  = 2'd3
    } apb_state_e;

    // Replace only the bytes whose strobe is set.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_timer_if.sv
// APB bus bundle shared by the timer and its bus master.
interface apb_timer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [3:0]            pstb;
    logic                  pready;
    logic                  perr;

    modport master (
        output paddr, pdata, psel, penable, pwrite, pstb,
        input  prdata, pready, perr
    );

    modport slave (
        input  paddr, pdata, psel, penable, pwrite, pstb,
        output prdata, pready, perr
    );
endinterface

// File: rtl/apb_resp_fsm.sv
// APB handshake sequencer with one wait state; reusable by any APB slave.
module apb_resp_fsm
    import soc_pkg::*;
(
    input  logic       clk,
    input  logic       rts,
    input  logic       psel,
    input  logic       penable,
    output apb_state_e state,
    output logic       pready,
    output logic       commit
);
    apb_state_e state_q, state_d;

    // NOTE: reset is sampled on the clock edge, so it lives inside the clocked branch.
    always_ff @(posedge clk) begin
        if (rts) state_q <= APB_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            APB_IDLE:  if (psel && !penable) state_d = APB_SETUP;
            APB_SETUP: if (psel && penable)  state_d = APB_WAIT;
            APB_WAIT:  state_d = APB_RESP;
            APB_RESP:  state_d = APB_IDLE;
            default:   state_d = APB_IDLE;
        endcase
        if (!psel) state_d = APB_IDLE;
    end

    assign state  = state_q;
    assign pready = (state_q == APB_RESP);
    assign commit = (state_q == APB_RESP) && psel;
endmodule

// File: rtl/apb_timer.sv
// 64-bit machine timer with compare interrupt behind an APB slave port.
// Define TIMER_PRESCALE_EN to enable the CTRL[15:8] tick prescaler.
module apb_timer
    import soc_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic       clk,
    input  logic       rts,
    apb_timer_if.slave apb,
    output logic       irq
);
    localparam int OFF_W = (ADDR_WIDTH < 5) ? ADDR_WIDTH : 5;

    apb_state_e state;
    logic       commit;

    logic [63:0]           mtime_q, mtime_d;
    logic [63:0]           cmp_q, cmp_d;
    logic [31:0]           snap_q, snap_d;
    logic                  en_q, en_d;
    logic                  irq_q, irq_d;
    logic                  perr_q, perr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
`ifdef TIMER_PRESCALE_EN
    logic [7:0]            presc_q, presc_d;
    logic [7:0]            cnt_q, cnt_d;
`endif

    logic [4:0]  off;
    logic        addr_err, wr_commit, rd_load, tick;
    logic [31:0] ctrl_rd, rd_val;

    apb_resp_fsm u_fsm (
        .clk     (clk),
        .rts     (rts),
        .psel    (apb.psel),
        .penable (apb.penable),
        .state   (state),
        .pready  (apb.pready),
        .commit  (commit)
    );

    assign off = 5'(apb.paddr[OFF_W-1:0]);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        addr_err  = (off > CTRL_OFF) || (off[1:0] != 2'b00);
        wr_commit = commit && apb.pwrite && !addr_err;
        rd_load   = (state == APB_WAIT) && apb.psel;

        ctrl_rd = '0;
        ctrl_rd[CTRL_EN_BIT] = en_q;
`ifdef TIMER_PRESCALE_EN
        ctrl_rd[CTRL_PRESC_MSB:CTRL_PRESC_LSB] = presc_q;
`endif
        case (off)
            MTIME_LO_OFF:    rd_val = mtime_q[31:0];
            MTIME_HI_OFF:    rd_val = snap_q;
            MTIMECMP_LO_OFF: rd_val = cmp_q[31:0];
            MTIMECMP_HI_OFF: rd_val = cmp_q[63:32];
            CTRL_OFF:        rd_val = ctrl_rd;
            default:         rd_val = '0;
        endcase

        // Read data exists only during RESP; errors and writes return zero.
        prdata_d = '0;
        perr_d   = 1'b0;
        snap_d   = snap_q;
        if (rd_load) begin
            perr_d = addr_err;
            if (!addr_err && !apb.pwrite) begin
                prdata_d = DATA_WIDTH'(rd_val);
                if (off == MTIME_LO_OFF) snap_d = mtime_q[63:32];
            end
        end

        en_d = en_q;
`ifdef TIMER_PRESCALE_EN
        presc_d = presc_q;
        cnt_d   = cnt_q;
        tick    = 1'b0;
        if (en_q) begin
            if (cnt_q == presc_q) begin
                tick  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
`else
        tick = en_q;
`endif

        cmp_d   = cmp_q;
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        if (wr_commit) begin
            case (off)
                MTIME_LO_OFF:    mtime_d = {mtime_q[63:32], strb_merge(mtime_q[31:0], apb.pdata, apb.pstb)};
                MTIME_HI_OFF:    mtime_d = {strb_merge(mtime_q[63:32], apb.pdata, apb.pstb), mtime_q[31:0]};
                MTIMECMP_LO_OFF: cmp_d[31:0]  = strb_merge(cmp_q[31:0], apb.pdata, apb.pstb);
                MTIMECMP_HI_OFF: cmp_d[63:32] = strb_merge(cmp_q[63:32], apb.pdata, apb.pstb);
                CTRL_OFF: begin
                    if (apb.pstb[0]) en_d = apb.pdata[CTRL_EN_BIT];
`ifdef TIMER_PRESCALE_EN
                    if (apb.pstb[1]) presc_d = apb.pdata[CTRL_PRESC_MSB:CTRL_PRESC_LSB];
                    if (|apb.pstb)   cnt_d   = '0;
`endif
                end
                default: ;
            endcase
        end

        irq_d = en_q && (mtime_q >= cmp_q);
    end

    always_ff @(posedge clk) begin
        if (rts) begin
            mtime_q  <= '0;
            cmp_q    <= MTIMECMP_RST;
            snap_q   <= '0;
            en_q     <= 1'b0;
            irq_q    <= 1'b0;
            perr_q   <= 1'b0;
            prdata_q <= '0;
`ifdef TIMER_PRESCALE_EN
            presc_q  <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            mtime_q  <= mtime_d;
            cmp_q    <= cmp_d;
            snap_q   <= snap_d;
            en_q     <= en_d;
            irq_q    <= irq_d;
            perr_q   <= perr_d;
            prdata_q <= prdata_d;
`ifdef TIMER_PRESCALE_EN
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign apb.prdata = prdata_q;
    assign apb.perr   = perr_q;
    assign irq        = irq_q;
endmodule

// File: tb/tb_apb_timer.sv
// Bench for apb_timer: directed register table, multi-cycle sequences and
// random APB traffic against a time-based arithmetic model of mtime.
module tb_apb_timer;
    import soc_pkg::*;

`ifdef TIMER_PRESCALE_EN
    localparam bit PRESC = 1'b1;
`else
    localparam bit PRESC = 1'b0;
`endif
    localparam logic [31:0] CTRL_FF_EXP = PRESC ? 32'h0000_FF00 : 32'h0;
    localparam logic [31:0] CTRL_31_EXP = PRESC ? 32'h0000_0301 : 32'h0000_0001;

    logic   clk = 1'b0;
    logic   rts = 1'b1;
    logic   irq;
    longint cyc = 0;
    int     checks = 0;
    int     errors = 0;

    apb_timer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_timer #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk (clk),
        .rts (rts),
        .apb (bus.slave),
        .irq (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // mtime is a function of the cycle count: a value loaded at edge m_ref
    // plus the number of ticks (every period cycles, phased from e_ref) since then.
    logic [63:0] m_val, m_cmp;
    logic [31:0] m_snap;
    logic [7:0]  m_presc;
    logic        m_en;
    longint      m_ref, e_ref;

    function automatic longint m_period();
        return PRESC ? longint'(m_presc) + 1 : 1;
    endfunction

    function automatic logic [63:0] model_mtime(input longint c);
        if (!m_en) return m_val;
        return m_val + 64'((c - e_ref) / m_period() - (m_ref - e_ref) / m_period());
    endfunction

    task automatic model_reset();
        m_val = '0; m_cmp = '1; m_snap = '0; m_presc = '0; m_en = 1'b0;
        m_ref = cyc; e_ref = cyc;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[4:0] > 5'h10) || (a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = s[i/8] ? n[i] : o[i];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input longint t);
        logic [63:0] mt;
        mt = model_mtime(t);
        if (addr_bad(a)) return 32'h0;
        case (a[4:0])
            5'h00:   return mt[31:0];
            5'h04:   return m_snap;
            5'h08:   return m_cmp[31:0];
            5'h0C:   return m_cmp[63:32];
            5'h10:   return {16'h0, (PRESC ? m_presc : 8'h0), 7'h0, m_en};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               input longint tc);
        logic [63:0] cur;
        if (addr_bad(a)) return;
        cur = model_mtime(tc - 1);
        case (a[4:0])
            5'h00: begin m_val = {cur[63:32], mrg(cur[31:0], d, s)}; m_ref = tc; end
            5'h04: begin m_val = {mrg(cur[63:32], d, s), cur[31:0]}; m_ref = tc; end
            5'h08: m_cmp[31:0]  = mrg(m_cmp[31:0], d, s);
            5'h0C: m_cmp[63:32] = mrg(m_cmp[63:32], d, s);
            5'h10: if (s != 4'h0) begin
                m_val = model_mtime(tc);
                m_ref = tc; e_ref = tc;
                if (s[0]) m_en = d[0];
                if (s[1]) m_presc = d[15:8];
            end
            default: ;
        endcase
    endtask

    // Called and returns 1 time unit after a rising edge.
    task automatic apb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd, output logic er,
                            output logic [31:0] exp_rd);
        int          lat;
        longint      t;
        logic [63:0] mt;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
        bus.paddr = a; bus.pdata = d; bus.pstb = s;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.pready && lat < 8);
        check("pready_latency", 64'(lat), 64'd2);
        rd = bus.prdata; er = bus.perr; t = cyc;
        exp_rd = model_read(a, t - 1);
        if (!wr && !addr_bad(a) && a[4:0] == 5'h00) begin
            mt = model_mtime(t - 1);
            m_snap = mt[63:32];
        end
        @(posedge clk); #1;
        check("pready_drop", 64'(bus.pready), 64'd0);
        bus.psel = 1'b0; bus.penable = 1'b0;
        if (wr) model_write(a, d, s, t + 1);
    endtask

    task automatic xfer_chk(input string tag, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd, ex;
        logic        er;
        apb_xfer(wr, a, d, s, rd, er, ex);
        check({tag, "_perr"}, 64'(er), 64'(addr_bad(a)));
        if (!wr) check({tag, "_prdata"}, 64'(rd), 64'(ex));
    endtask

    task automatic check_irq(input string tag);
        logic exp;
        @(posedge clk); #1;
        exp = m_en && (model_mtime(cyc - 1) >= m_cmp);
        check(tag, 64'(irq), 64'(exp));
    endtask

    task automatic reset_dut();
        rts = 1'b1;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = '0; bus.pdata = '0; bus.pstb = '0;
        repeat (2) @(posedge clk);
        #1 rts = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        exp_err;
        logic        chk_rd;
        logic [31:0] exp_rd;
        string       name;
    } vec_t;

    function automatic vec_t v(input logic wr, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, input logic e, input logic c,
                               input logic [31:0] x, input string n);
        vec_t r;
        r.wr = wr; r.addr = a; r.data = d; r.strb = s;
        r.exp_err = e; r.chk_rd = c; r.exp_rd = x; r.name = n;
        return r;
    endfunction

    vec_t vt[$];

    initial begin
        logic [31:0] rd, ex, a, d;
        logic [3:0]  s;
        logic        er;
        longint      c, rise, exp_rise;
        logic [31:0] offs [5];
        offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10};

        vt.push_back(v(0, 32'h10, 32'h0,         4'h0, 0, 1, 32'h0,         "rst_ctrl"));
        vt.push_back(v(0, 32'h00, 32'h0,         4'h0, 0, 1, 32'h0,         "rst_mtime_lo"));
        vt.push_back(v(0, 32'h04, 32'h0,         4'h0, 0, 1, 32'h0,         "rst_mtime_hi"));
        vt.push_back(v(0, 32'h08, 32'h0,         4'h0, 0, 1, 32'hFFFF_FFFF, "rst_cmp_lo"));
        vt.push_back(v(0, 32'h0C, 32'h0,         4'h0, 0, 1, 32'hFFFF_FFFF, "rst_cmp_hi"));
        vt.push_back(v(1, 32'h08, 32'hAABB_CCDD, 4'h2, 0, 0, 32'h0,         "wr_cmp_lo_b1"));
        vt.push_back(v(0, 32'h08, 32'h0,         4'h0, 0, 1, 32'hFFFF_CCFF, "cmp_lo_strobe"));
        vt.push_back(v(0, 32'h14, 32'h0,         4'h0, 1, 1, 32'h0,         "rd_0x14"));
        vt.push_back(v(0, 32'h06, 32'h0,         4'h0, 1, 1, 32'h0,         "rd_0x06"));
        vt.push_back(v(1, 32'h14, 32'h1111_1111, 4'hF, 1, 0, 32'h0,         "wr_0x14"));
        vt.push_back(v(1, 32'h06, 32'h2222_2222, 4'hF, 1, 0, 32'h0,         "wr_0x06"));
        vt.push_back(v(1, 32'h0D, 32'h0,         4'hF, 1, 0, 32'h0,         "wr_0x0d"));
        vt.push_back(v(0, 32'h00, 32'h0,         4'h0, 0, 1, 32'h0,         "after_err_lo"));
        vt.push_back(v(0, 32'h04, 32'h0,         4'h0, 0, 1, 32'h0,         "after_err_hi"));
        vt.push_back(v(0, 32'h0C, 32'h0,         4'h0, 0, 1, 32'hFFFF_FFFF, "after_err_cmp_hi"));
        vt.push_back(v(0, 32'h10, 32'h0,         4'h0, 0, 1, 32'h0,         "after_err_ctrl"));
        vt.push_back(v(1, 32'h0C, 32'h0,         4'h0, 0, 0, 32'h0,         "wr_strb0"));
        vt.push_back(v(0, 32'h0C, 32'h0,         4'h0, 0, 1, 32'hFFFF_FFFF, "strb0_no_change"));
        vt.push_back(v(1, 32'h10, 32'hFFFF_FF00, 4'hF, 0, 0, 32'h0,         "wr_ctrl_ff"));
        vt.push_back(v(0, 32'h10, 32'h0,         4'h0, 0, 1, CTRL_FF_EXP,   "ctrl_mask"));
        vt.push_back(v(1, 32'h10, 32'h0,         4'hF, 0, 0, 32'h0,         "wr_ctrl_0"));
        vt.push_back(v(1, 32'h04, 32'h1234_5678, 4'hF, 0, 0, 32'h0,         "wr_mtime_hi"));
        vt.push_back(v(1, 32'h00, 32'h9ABC_DEF0, 4'hF, 0, 0, 32'h0,         "wr_mtime_lo"));
        vt.push_back(v(0, 32'h04, 32'h0,         4'h0, 0, 1, 32'h0,         "hi_before_snap"));
        vt.push_back(v(0, 32'h00, 32'h0,         4'h0, 0, 1, 32'h9ABC_DEF0, "mtime_lo_rb"));
        vt.push_back(v(0, 32'h04, 32'h0,         4'h0, 0, 1, 32'h1234_5678, "mtime_hi_snap"));

        reset_dut();
        check("rst_irq", 64'(irq), 64'd0);
        check("rst_pready", 64'(bus.pready), 64'd0);
        for (int i = 0; i < vt.size(); i++) begin
            apb_xfer(vt[i].wr, vt[i].addr, vt[i].data, vt[i].strb, rd, er, ex);
            check({vt[i].name, "_perr"}, 64'(er), 64'(vt[i].exp_err));
            if (vt[i].chk_rd) check(vt[i].name, 64'(rd), 64'(vt[i].exp_rd));
        end
        check_irq("table_irq");

        // irq rises one cycle after mtime reaches the compare value
        reset_dut();
        xfer_chk("cmp_hi0", 1, 32'h0C, 32'h0, 4'hF);
        xfer_chk("cmp_lo20", 1, 32'h08, 32'd20, 4'hF);
        xfer_chk("en1", 1, 32'h10, 32'h1, 4'hF);
        c = e_ref;
        while (model_mtime(c) < 64'd20 && c < e_ref + 1000) c++;
        exp_rise = c + 1;
        rise = -1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (irq && rise < 0) rise = cyc;
        end
        check("irq_rise_cycle", 64'(rise), 64'(exp_rise));
        xfer_chk("cmp_lo_above", 1, 32'h08, 32'hFFFF_FFFF, 4'hF);
        check_irq("irq_clr_cmp");
        xfer_chk("cmp_lo_5", 1, 32'h08, 32'd5, 4'hF);
        check_irq("irq_set_again");
        xfer_chk("en0", 1, 32'h10, 32'h0, 4'hF);
        check_irq("irq_clr_en");
        xfer_chk("frozen_lo", 0, 32'h00, 32'h0, 4'h0);
        repeat (5) @(posedge clk);
        #0 xfer_chk("frozen_lo2", 0, 32'h00, 32'h0, 4'h0);

        // wrap of mtime across 2^64 with compare at the top value
        xfer_chk("wrap_lo", 1, 32'h00, 32'hFFFF_FFFE, 4'hF);
        xfer_chk("wrap_hi", 1, 32'h04, 32'hFFFF_FFFF, 4'hF);
        xfer_chk("wrap_cmp_lo", 1, 32'h08, 32'hFFFF_FFFF, 4'hF);
        xfer_chk("wrap_cmp_hi", 1, 32'h0C, 32'hFFFF_FFFF, 4'hF);
        xfer_chk("wrap_en", 1, 32'h10, 32'h1, 4'hF);
        for (int k = 0; k < 6; k++) check_irq("wrap_irq");
        xfer_chk("wrap_rd_lo", 0, 32'h00, 32'h0, 4'h0);
        xfer_chk("wrap_rd_hi", 0, 32'h04, 32'h0, 4'h0);

        // prescaled tick rate and CTRL field readback
        xfer_chk("presc_wr", 1, 32'h10, 32'h0000_0301, 4'hF);
        apb_xfer(0, 32'h10, 32'h0, 4'h0, rd, er, ex);
        check("ctrl_0301_rb", 64'(rd), 64'(CTRL_31_EXP));
        for (int k = 0; k < 4; k++) xfer_chk("presc_lo", 0, 32'h00, 32'h0, 4'h0);

        // reset during a transfer aborts it without a pready pulse
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 32'h08; bus.pdata = 32'h1234_5678; bus.pstb = 4'hF;
        @(posedge clk); #1 bus.penable = 1'b1;
        @(posedge clk); #1 rts = 1'b1;
        @(posedge clk); #1;
        check("abort_pready", 64'(bus.pready), 64'd0);
        rts = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check("abort_pready_after", 64'(bus.pready), 64'd0);
        apb_xfer(0, 32'h08, 32'h0, 4'h0, rd, er, ex);
        check("abort_cmp_lo", 64'(rd), 64'hFFFF_FFFF);

        // random traffic against the model
        for (int i = 0; i < 80; i++) begin
            a = ($urandom_range(0, 5) < 5) ? offs[$urandom_range(0, 4)] : 32'($urandom_range(0, 31));
            a = a | ($urandom() & 32'hFFFF_FFE0);
            d = $urandom();
            if (a[4:0] == 5'h10)
                d = {16'h0, 6'h0, 2'($urandom_range(0, 3)), 7'h0, 1'($urandom_range(0, 3) != 0)};
            s = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            xfer_chk("rand", 1'($urandom_range(0, 1)), a, d, s);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            check_irq("rand_irq");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
